// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared types and defaults for the VRAM arbiter
//
// Contents:
//   AW_DEF, DW_DEF : default VRAM address / data widths
//   cpu_state_t    : CPU handshake FSM states (S_IDLE, S_RD, S_ACK)
//   slot_tag_t     : per-slot tag {vid, cpu_rd} that follows a read through the RAM latency
package vram_pkg;

    localparam int AW_DEF = 14;
    localparam int DW_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_ACK  = 2'd2
    } cpu_state_t;

    typedef struct packed {
        logic vid;
        logic cpu_rd;
    } slot_tag_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// rtl/vram_arbiter_if.sv - video / CPU / VRAM bus bundle for the VRAM arbiter
//
// Signals:
//   vid_req, vid_addr, vid_hblank, vid_vblank -> arbiter ; vid_valid, vid_data <- arbiter
//   cpu_req, cpu_we, cpu_addr, cpu_wdata      -> arbiter ; cpu_ack, cpu_rdata  <- arbiter
//   ram_addr, ram_we, ram_wdata <- arbiter ; ram_rdata -> arbiter
// Modports:
//   slave  : the arbiter
//   master : the requesters and the VRAM macro around it
interface vram_arbiter_if #(
    parameter int AW = vram_pkg::AW_DEF,
    parameter int DW = vram_pkg::DW_DEF
);
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_hblank;
    logic          vid_vblank;
    logic          vid_valid;
    logic [DW-1:0] vid_data;

    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;

    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    modport slave (
        input  vid_req, vid_addr, vid_hblank, vid_vblank,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ram_rdata,
        output vid_valid, vid_data, cpu_ack, cpu_rdata,
        output ram_addr, ram_we, ram_wdata
    );

    modport master (
        output vid_req, vid_addr, vid_hblank, vid_vblank,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ram_rdata,
        input  vid_valid, vid_data, cpu_ack, cpu_rdata,
        input  ram_addr, ram_we, ram_wdata
    );

endinterface

// File: rtl/vram_arbiter_sat_counter.sv
// rtl/vram_arbiter_sat_counter.sv - W-bit saturating up counter with clear
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : count up by one (sticks at all-ones)
//   clr        : clear to zero, wins over inc
//   count      : current value
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM arbiter: video fetch has absolute priority, CPU takes free slots
//
// Ports:
//   pclk, reset_n : pixel clock, asynchronous active-low reset
//   bus (slave)   : video fetch, CPU req/ack and VRAM signals (see vram_arbiter_if)
//   cpu_wait_max  : longest CPU wait (cycles) seen since reset, saturating
// Build option:
//   VRAM_ARB_BLANK_ONLY_EN : CPU slots are only granted while vid_hblank | vid_vblank
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int AW  = AW_DEF,
    parameter int DW  = DW_DEF,
    parameter int WCW = 8
) (
    input  logic           pclk,
    input  logic           reset_n,
    vram_arbiter_if.slave  bus,
    output logic [WCW-1:0] cpu_wait_max
);

    cpu_state_t     state;
    slot_tag_t      tag_s1;
    slot_tag_t      tag_s2;
    logic           blank_ok;
    logic           cpu_elig;
    logic           cpu_grant;
    logic           wait_inc;
    logic [WCW-1:0] wait_cnt;

`ifdef VRAM_ARB_BLANK_ONLY_EN
    assign blank_ok = bus.vid_hblank | bus.vid_vblank;
`else
    logic unused_blank;
    assign unused_blank = bus.vid_hblank ^ bus.vid_vblank;
    assign blank_ok     = 1'b1;
`endif

    // The ack cycle is excluded so a held cpu_req is not mistaken for a new request.
    assign cpu_elig  = bus.cpu_req && (state == S_IDLE) && !bus.cpu_ack && blank_ok;
    assign cpu_grant = !bus.vid_req && cpu_elig;
    assign wait_inc  = bus.cpu_req && (state == S_IDLE) && !cpu_grant;

    sat_counter #(.W(WCW)) u_wait_cnt (
        .clk   (pclk),
        .rst_n (reset_n),
        .inc   (wait_inc),
        .clr   (cpu_grant),
        .count (wait_cnt)
    );

    // Slot decision, tag pipeline and video return path.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            bus.ram_addr  <= '0;
            bus.ram_we    <= 1'b0;
            bus.ram_wdata <= '0;
            tag_s1        <= '0;
            tag_s2        <= '0;
            bus.vid_valid <= 1'b0;
            bus.vid_data  <= '0;
            cpu_wait_max  <= '0;
        end else begin
            if (bus.vid_req) begin
                bus.ram_addr <= bus.vid_addr;
                bus.ram_we   <= 1'b0;
            end else if (cpu_grant) begin
                bus.ram_addr  <= bus.cpu_addr;
                bus.ram_we    <= bus.cpu_we;
                bus.ram_wdata <= bus.cpu_wdata;
            end else begin
                bus.ram_we <= 1'b0;
            end

            tag_s1.vid    <= bus.vid_req;
            tag_s1.cpu_rd <= cpu_grant && !bus.cpu_we;
            tag_s2        <= tag_s1;

            // tag_s2 lines up with the cycle in which ram_rdata belongs to that slot.
            bus.vid_valid <= tag_s2.vid;
            if (tag_s2.vid) begin
                bus.vid_data <= bus.ram_rdata;
            end

            if (cpu_grant && (wait_cnt > cpu_wait_max)) begin
                cpu_wait_max <= wait_cnt;
            end
        end
    end

    // CPU handshake. Writes also pass through S_RD so that reads and writes
    // are acknowledged with the same two-cycle latency after the grant.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            bus.cpu_ack   <= 1'b0;
            bus.cpu_rdata <= '0;
        end else begin
            bus.cpu_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cpu_grant) begin
                        state <= S_RD;
                    end
                end
                S_RD: begin
                    state <= S_ACK;
                end
                S_ACK: begin
                    bus.cpu_ack <= 1'b1;
                    if (tag_s2.cpu_rd) begin
                        bus.cpu_rdata <= bus.ram_rdata;
                    end
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - scoreboard bench for vram_arbiter with VRAM model and reference model
module tb_vram_arbiter;
    import vram_pkg::*;

    localparam int AW  = 14;
    localparam int DW  = 8;
    localparam int WCW = 8;

    logic           pclk    = 1'b0;
    logic           reset_n = 1'b1;
    logic [WCW-1:0] cpu_wait_max;

    vram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    vram_arbiter #(.AW(AW), .DW(DW), .WCW(WCW)) dut (
        .pclk         (pclk),
        .reset_n      (reset_n),
        .bus          (bus),
        .cpu_wait_max (cpu_wait_max)
    );

    always #5 pclk = ~pclk;

    // VRAM macro: synchronous, read-first.
    logic [DW-1:0] mem     [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    always @(posedge pclk) begin
        bus.ram_rdata <= mem[bus.ram_addr];
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    end

    typedef struct {
        int            edge_no;
        logic [DW-1:0] data;
        logic          chk_data;
    } rsp_t;

    typedef struct {
        logic [AW-1:0]  addr;
        logic           we;
        logic [DW-1:0]  wdata;
        logic [WCW-1:0] wmax;
    } slot_t;

    rsp_t  vid_q[$];
    rsp_t  cpu_q[$];
    slot_t slot_q[$];

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    logic in_reset = 1'b1;

    // Reference model state: last grant edge, earliest next CPU grant, wait counting.
    int             g_last     = -100;
    int             ack_edge_m = -100;
    int             cpu_ok     = 0;
    int             wait_m     = 0;
    logic [WCW-1:0] wmax_m     = '0;
    logic [AW-1:0]  addr_m     = '0;
    logic           we_m       = 1'b0;
    logic [DW-1:0]  wdata_m    = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp_v, cyc - 1);
        end
    endtask

    function automatic void model_reset();
        g_last     = -100;
        ack_edge_m = -100;
        cpu_ok     = cyc;
        wait_m     = 0;
        wmax_m     = '0;
        addr_m     = '0;
        we_m       = 1'b0;
        wdata_m    = '0;
    endfunction

    // Predict what the arbiter does at the coming edge (numbered cyc).
    task automatic model_step();
        slot_t s;
        rsp_t  r;
        logic  blank_ok;
        logic  cpu_busy;
`ifdef VRAM_ARB_BLANK_ONLY_EN
        blank_ok = bus.vid_hblank | bus.vid_vblank;
`else
        blank_ok = 1'b1;
`endif
        cpu_busy = (cyc == g_last + 1) || (cyc == g_last + 2);
        if (bus.vid_req) begin
            addr_m     = bus.vid_addr;
            we_m       = 1'b0;
            r.edge_no  = cyc + 2;
            r.data     = ref_mem[bus.vid_addr];
            r.chk_data = 1'b1;
            vid_q.push_back(r);
            if (bus.cpu_req && !cpu_busy && wait_m < 255) wait_m++;
        end else if (bus.cpu_req && cyc >= cpu_ok && blank_ok) begin
            if (WCW'(wait_m) > wmax_m) wmax_m = WCW'(wait_m);
            wait_m     = 0;
            g_last     = cyc;
            cpu_ok     = cyc + 4;
            ack_edge_m = cyc + 2;
            addr_m     = bus.cpu_addr;
            we_m       = bus.cpu_we;
            wdata_m    = bus.cpu_wdata;
            if (bus.cpu_we) ref_mem[bus.cpu_addr] = bus.cpu_wdata;
            r.edge_no  = cyc + 2;
            r.data     = ref_mem[bus.cpu_addr];
            r.chk_data = !bus.cpu_we;
            cpu_q.push_back(r);
        end else begin
            we_m = 1'b0;
            if (bus.cpu_req && !cpu_busy && wait_m < 255) wait_m++;
        end
        s.addr  = addr_m;
        s.we    = we_m;
        s.wdata = wdata_m;
        s.wmax  = wmax_m;
        slot_q.push_back(s);
    endtask

    task automatic tick();
        model_step();
        @(posedge pclk);
        cyc++;
        in_reset = 1'b0;
        #1;
    endtask

    task automatic set_cpu(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
    endtask

    task automatic rand_cpu();
        set_cpu(1'($urandom_range(1)), AW'($urandom_range(31)), DW'($urandom));
    endtask

    // Keep ticking until the model's ack for the outstanding CPU request, then drop cpu_req.
    task automatic finish_cpu();
        bit done = 1'b0;
        for (int i = 0; i < 80 && !done; i++) begin
            tick();
            if (ack_edge_m == cyc - 1) done = 1'b1;
        end
        if (!done) check("cpu_ack_timeout", 32'(done), 32'd1);
        bus.cpu_req = 1'b0;
    endtask

    task automatic cpu_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        set_cpu(we, a, d);
        finish_cpu();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ram_addr"},  32'(bus.ram_addr),  32'd0);
        check({tag, "_ram_we"},    32'(bus.ram_we),    32'd0);
        check({tag, "_ram_wdata"}, 32'(bus.ram_wdata), 32'd0);
        check({tag, "_vid_valid"}, 32'(bus.vid_valid), 32'd0);
        check({tag, "_vid_data"},  32'(bus.vid_data),  32'd0);
        check({tag, "_cpu_ack"},   32'(bus.cpu_ack),   32'd0);
        check({tag, "_cpu_rdata"}, 32'(bus.cpu_rdata), 32'd0);
        check({tag, "_wait_max"},  32'(cpu_wait_max),  32'd0);
    endtask

    // Monitor: compares every slot and every returned strobe against the queues.
    initial begin
        slot_t s;
        rsp_t  r;
        forever begin
            @(negedge pclk);
            if (!in_reset) begin
                if (slot_q.size() != 0) begin
                    s = slot_q.pop_front();
                    check("ram_addr",     32'(bus.ram_addr),  32'(s.addr));
                    check("ram_we",       32'(bus.ram_we),    32'(s.we));
                    check("ram_wdata",    32'(bus.ram_wdata), 32'(s.wdata));
                    check("cpu_wait_max", 32'(cpu_wait_max),  32'(s.wmax));
                end
                if (bus.vid_valid) begin
                    if (vid_q.size() == 0) begin
                        check("vid_valid_unexpected", 32'(bus.vid_valid), 32'd0);
                    end else begin
                        r = vid_q.pop_front();
                        check("vid_latency", 32'(cyc - 1), 32'(r.edge_no));
                        check("vid_data",    32'(bus.vid_data), 32'(r.data));
                    end
                end else if (vid_q.size() != 0 && vid_q[0].edge_no <= cyc - 1) begin
                    check("vid_valid_missing", 32'(bus.vid_valid), 32'd1);
                    void'(vid_q.pop_front());
                end
                if (bus.cpu_ack) begin
                    if (cpu_q.size() == 0) begin
                        check("cpu_ack_unexpected", 32'(bus.cpu_ack), 32'd0);
                    end else begin
                        r = cpu_q.pop_front();
                        check("cpu_ack_latency", 32'(cyc - 1), 32'(r.edge_no));
                        if (r.chk_data) check("cpu_rdata", 32'(bus.cpu_rdata), 32'(r.data));
                    end
                end else if (cpu_q.size() != 0 && cpu_q[0].edge_no <= cyc - 1) begin
                    check("cpu_ack_missing", 32'(bus.cpu_ack), 32'd1);
                    void'(cpu_q.pop_front());
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]     = DW'($urandom);
            ref_mem[i] = mem[i];
        end
        bus.vid_req    = 1'b0;
        bus.vid_addr   = '0;
        bus.vid_hblank = 1'b1;
        bus.vid_vblank = 1'b0;
        bus.cpu_req    = 1'b0;
        bus.cpu_we     = 1'b0;
        bus.cpu_addr   = '0;
        bus.cpu_wdata  = '0;

        #1 reset_n = 1'b0;
        #2 check_all_zero("reset");
        @(negedge pclk);
        #1 reset_n = 1'b1;

        // Lone CPU write.
        set_cpu(1'b1, 14'h0123, 8'hA5);
        tick();
        check("t1_ram_we",   32'(bus.ram_we),   32'd1);
        check("t1_ram_addr", 32'(bus.ram_addr), 32'h0123);
        finish_cpu();
        check("t1_wait_max", 32'(cpu_wait_max), 32'd0);
        tick();

        // CPU read-back of the same word.
        cpu_access(1'b0, 14'h0123, 8'h00);
        check("t2_cpu_ack",   32'(bus.cpu_ack),   32'd1);
        check("t2_cpu_rdata", 32'(bus.cpu_rdata), 32'hA5);
        check("t2_vid_valid", 32'(bus.vid_valid), 32'd0);
        tick();

        // Simultaneous request; video held 5 cycles.
        set_cpu(1'b1, 14'h0200, 8'h3C);
        for (int i = 0; i < 5; i++) begin
            bus.vid_req  = 1'b1;
            bus.vid_addr = AW'(14'h0100 + i);
            tick();
        end
        bus.vid_req = 1'b0;
        finish_cpu();
        check("t4_wait_max", 32'(cpu_wait_max), 32'd5);
        repeat (3) tick();

`ifdef VRAM_ARB_BLANK_ONLY_EN
        // CPU held through active display, then released by hblank.
        bus.vid_hblank = 1'b0;
        bus.vid_vblank = 1'b0;
        set_cpu(1'b1, 14'h0300, 8'h77);
        repeat (20) tick();
        bus.vid_hblank = 1'b1;
        tick();
        check("t5_grant_in_blank", 32'(bus.ram_we), 32'd1);
        finish_cpu();
        check("t5_wait_max", 32'(cpu_wait_max), 32'd20);
        repeat (3) tick();
`endif

        // Video every 4th cycle with the CPU continuously requesting.
        rand_cpu();
        for (int i = 0; i < 48; i++) begin
            bus.vid_req  = (i % 4 == 0);
            bus.vid_addr = AW'(i / 4);
            tick();
            if (ack_edge_m == cyc - 1) rand_cpu();
        end
        bus.vid_req = 1'b0;
        finish_cpu();
        repeat (3) tick();

        // Reset in the cycle after a CPU read grant.
        set_cpu(1'b0, 14'h0123, 8'h00);
        for (int i = 0; i < 20 && g_last != cyc - 1; i++) tick();
        check("t6_read_granted", 32'(g_last), 32'(cyc - 1));
        reset_n     = 1'b0;
        in_reset    = 1'b1;
        bus.cpu_req = 1'b0;
        vid_q.delete();
        cpu_q.delete();
        slot_q.delete();
        #1 check_all_zero("t6_reset");
        repeat (3) @(posedge pclk);
        cyc += 3;
        @(negedge pclk);
        #1 reset_n = 1'b1;
        model_reset();
        repeat (4) tick();
        cpu_access(1'b0, 14'h0123, 8'h00);
        check("t6_after_reset_rdata", 32'(bus.cpu_rdata), 32'hA5);
        tick();

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            bus.vid_req    = ($urandom_range(2) == 0);
            bus.vid_addr   = AW'($urandom_range(31));
            bus.vid_hblank = 1'($urandom_range(1));
            bus.vid_vblank = ($urandom_range(3) == 0);
            if (!bus.cpu_req && $urandom_range(1) == 1) rand_cpu();
            tick();
            if (bus.cpu_req && ack_edge_m == cyc - 1) begin
                if ($urandom_range(1) == 1) rand_cpu();
                else bus.cpu_req = 1'b0;
            end
        end
        bus.vid_req    = 1'b0;
        bus.vid_hblank = 1'b1;
        if (bus.cpu_req) finish_cpu();
        repeat (5) tick();

        check("vid_q_drained", 32'(vid_q.size()), 32'd0);
        check("cpu_q_drained", 32'(cpu_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
